// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shared-multiplier front end.
package mul_pkg;

    localparam int unsigned MUL_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Per-requester request/response channel to mul_seq.
interface mul_seq_if;

    logic        valid;
    logic        ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output valid, op, a, b, flush, rsp_ready,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, op, a, b, flush, rsp_ready,
        output ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic ptr;

    // Grant the single requester, or the pointed-to one when both ask
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // On an accepted grant, point at the requester that lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Sequences two requesters onto one shared multicycle multiplier.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_seq_if.slave    req0,
    mul_seq_if.slave    req1,
    output logic [1:0]  mul_ctrl_o,
    output logic [31:0] mul_in1_o,
    output logic [31:0] mul_in2_o,
    input  logic [31:0] mul_out_i,
    output logic        busy
);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    mul_op_t     op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        owner_q;
    logic [31:0] result_q;

    logic [1:0]  req_vec;
    logic [1:0]  gnt;
    logic        idle;
    logic        accept;
    logic        owner_flush;
    logic        owner_rsp_ready;

    assign req_vec         = {req1.valid & ~req1.flush, req0.valid & ~req0.flush};
    assign idle            = (state_q == IDLE);
    assign accept          = idle & (|gnt);
    assign owner_flush     = owner_q ? req1.flush : req0.flush;
    assign owner_rsp_ready = owner_q ? req1.rsp_ready : req0.rsp_ready;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vec),
        .update (accept),
        .gnt    (gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; owner flush overrides a same-cycle response handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                if (owner_flush)        state_d = IDLE;
                else if (cnt_q == '0)   state_d = DONE;
            end
            DONE: begin
                if (owner_flush)          state_d = IDLE;
                else if (owner_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; ready is gated by rst_n so it reads 0 throughout reset
    always_comb begin
        req0.ready     = rst_n & idle & gnt[0];
        req1.ready     = rst_n & idle & gnt[1];
        req0.rsp_valid = (state_q == DONE) & ~owner_q;
        req1.rsp_valid = (state_q == DONE) & owner_q;
        req0.rsp_data  = result_q;
        req1.rsp_data  = result_q;
        busy           = ~idle;
    end

    // Capture request, count down the multiplier latency, sample the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= MUL;
            a_q      <= '0;
            b_q      <= '0;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= 4'(MUL_LAT - 1);
                owner_q <= gnt[1];
                op_q    <= mul_op_t'(gnt[1] ? req1.op : req0.op);
                a_q     <= gnt[1] ? req1.a : req0.a;
                b_q     <= gnt[1] ? req1.b : req0.b;
            end else if (state_q == EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == EXEC && cnt_q == '0) begin
                result_q <= mul_out_i;
            end
        end
    end

    assign mul_ctrl_o = op_q;
    assign mul_in1_o  = a_q;
    assign mul_in2_o  = b_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed scoreboard bench for mul_seq with a behavioural multiplier.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mul_ctrl_o;
    logic [31:0] mul_in1_o;
    logic [31:0] mul_in2_o;
    logic [31:0] mul_out_i;
    logic        busy;

    mul_seq_if r0 ();
    mul_seq_if r1 ();

    mul_seq #(.MUL_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (r0),
        .req1       (r1),
        .mul_ctrl_o (mul_ctrl_o),
        .mul_in1_o  (mul_in1_o),
        .mul_in2_o  (mul_in2_o),
        .mul_out_i  (mul_out_i),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: extend per op, 64-bit product, pick half
    logic [63:0] ea, eb, prod;
    always_comb begin
        ea = {32'd0, mul_in1_o};
        eb = {32'd0, mul_in2_o};
        if (mul_ctrl_o == 2'b01 || mul_ctrl_o == 2'b10) ea = {{32{mul_in1_o[31]}}, mul_in1_o};
        if (mul_ctrl_o == 2'b01) eb = {{32{mul_in2_o[31]}}, mul_in2_o};
        prod = ea * eb;
        mul_out_i = (mul_ctrl_o == 2'b00) ? prod[31:0] : prod[63:32];
    end

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expd);
        checks++;
        if (act !== expd) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expd);
        end
    endtask

    task automatic handle_rsp(input int id, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: req%0d data 0x%08h with nothing expected", id, data);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(id), 32'(e.id));
            chk("rsp_data", data, e.data);
        end
    endtask

    // Monitor: every response handshake is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (r0.rsp_valid && r0.rsp_ready) handle_rsp(0, r0.rsp_data);
            if (r1.rsp_valid && r1.rsp_ready) handle_rsp(1, r1.rsp_data);
        end
    end

    task automatic accept(input int id, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expd, input bit push,
                          output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        if (id == 0) begin r0.valid = 1'b1; r0.op = op; r0.a = a; r0.b = b; end
        else         begin r1.valid = 1'b1; r1.op = op; r1.a = a; r1.b = b; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id == 0 && r0.ready) || (id == 1 && r1.ready)) begin
                got = 1'b1;
                if (push) sb.push_back('{id, expd});
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req%0d never ready, required 1", id);
        end
        if (id == 0) r0.valid = 1'b0;
        else         r1.valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy %0b pending %0d, required 0 0", busy, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ctrl"}, 32'(mul_ctrl_o), 32'd0);
        chk({tag, "_in1"}, mul_in1_o, 32'd0);
        chk({tag, "_in2"}, mul_in2_o, 32'd0);
        chk({tag, "_rdy"}, {30'd0, r1.ready, r0.ready}, 32'd0);
        chk({tag, "_rspv"}, {30'd0, r1.rsp_valid, r0.rsp_valid}, 32'd0);
        chk({tag, "_rspd"}, r0.rsp_data | r1.rsp_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  t_op  [4];
        logic [31:0] t_a   [4];
        logic [31:0] t_b   [4];
        logic [31:0] t_exp [4];
        int w, k, cur0, cur1, g;
        bit timed_out;

        t_op  = '{2'b01, 2'b11, 2'b10, 2'b00};
        t_a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
        t_b   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
        t_exp = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

        rst_n = 1'b0;
        r0.valid = 1'b1; r0.op = '0; r0.a = 32'd1; r0.b = 32'd1; r0.flush = 1'b0; r0.rsp_ready = 1'b1;
        r1.valid = 1'b0; r1.op = '0; r1.a = '0;    r1.b = '0;    r1.flush = 1'b0; r1.rsp_ready = 1'b1;

        // Reset state with a valid request pending
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0.valid = 1'b0;

        // 7 * 6 = 42 with exact response timing
        accept(0, 2'b00, 32'd7, 32'd6, 32'd42, 1'b1, w);
        chk("t1_accept_cycle", 32'(w), 32'd0);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in1", mul_in1_o, 32'd7);
        chk("t1_in2", mul_in2_o, 32'd6);
        chk("t1_rspv_c1", 32'(r0.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rspv_c2", 32'(r0.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rspv_c3", 32'(r0.rsp_valid), 32'd1);
        @(posedge clk); #1;
        wait_idle();

        // Fresh reset, then both requesters contend: grants 0,1,0,1
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur0 = 0; cur1 = 1; k = 0;
        r0.valid = 1'b1; r0.op = t_op[0]; r0.a = t_a[0]; r0.b = t_b[0];
        r1.valid = 1'b1; r1.op = t_op[1]; r1.a = t_a[1]; r1.b = t_b[1];
        timed_out = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy) chk("rr_no_ready_busy", {30'd0, r1.ready, r0.ready}, 32'd0);
            g = -1;
            if (r0.ready || r1.ready) begin
                chk("rr_one_ready", 32'(r0.ready & r1.ready), 32'd0);
                g = r1.ready ? 1 : 0;
                chk("rr_grant_order", 32'(g), 32'(k % 2));
                sb.push_back('{g, t_exp[(g == 1) ? cur1 : cur0]});
                k++;
            end
            @(posedge clk); #1;
            if (g == 0) begin
                cur0 += 2;
                if (cur0 < 4) begin r0.op = t_op[cur0]; r0.a = t_a[cur0]; r0.b = t_b[cur0]; end
                else r0.valid = 1'b0;
            end else if (g == 1) begin
                cur1 += 2;
                if (cur1 < 4) begin r1.op = t_op[cur1]; r1.a = t_a[cur1]; r1.b = t_b[cur1]; end
                else r1.valid = 1'b0;
            end
            if (k == 4) begin
                timed_out = 1'b0;
                break;
            end
        end
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        if (timed_out) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout: %0d grants seen, required 4", k);
        end
        wait_idle();

        // Owner flush in first EXEC cycle: no response, req0 taken right after
        accept(1, 2'b00, 32'd9, 32'd9, 32'd0, 1'b0, w);
        r1.flush = 1'b1;
        r0.valid = 1'b1; r0.op = 2'b00; r0.a = 32'd4; r0.b = 32'd5;
        @(negedge clk);
        chk("fl_busy_exec", 32'(busy), 32'd1);
        chk("fl_rdy0_exec", 32'(r0.ready), 32'd0);
        @(posedge clk); #1;
        r1.flush = 1'b0;
        @(negedge clk);
        chk("fl_busy_after", 32'(busy), 32'd0);
        chk("fl_rdy0_after", 32'(r0.ready), 32'd1);
        if (r0.ready) sb.push_back('{0, 32'd20});
        @(posedge clk); #1;
        r0.valid = 1'b0;
        wait_idle();

        // Response backpressure with req1 waiting
        r0.rsp_ready = 1'b0;
        accept(0, 2'b00, 32'd11, 32'd13, 32'd143, 1'b1, w);
        r1.valid = 1'b1; r1.op = 2'b00; r1.a = 32'd2; r1.b = 32'd21;
        timed_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r0.rsp_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) begin
            checks++;
            errors++;
            $display("FAIL bp_timeout: rsp0_valid 0, required 1");
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_data", r0.rsp_data, 32'd143);
            chk("bp_rsp_valid", 32'(r0.rsp_valid), 32'd1);
            chk("bp_rdy1", 32'(r1.ready), 32'd0);
            @(posedge clk); #1;
            if (i < 4) @(negedge clk);
        end
        r0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy1_handshake", 32'(r1.ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_rdy1_next", 32'(r1.ready), 32'd1);
        if (r1.ready) sb.push_back('{1, 32'd42});
        @(posedge clk); #1;
        r1.valid = 1'b0;
        wait_idle();

        // Asynchronous reset mid-EXEC drops the operation
        accept(0, 2'b11, 32'd100, 32'd100, 32'd0, 1'b0, w);
        r0.valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0.valid = 1'b0;
        accept(0, 2'b00, 32'd3, 32'd5, 32'd15, 1'b1, w);
        wait_idle();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
